// File: rtl/out_port_hex_display.sv
// Converts three 5-bit CPU output ports to two decimal digits each (subtract-by-ten)
// and drives six registered, active-low seven-segment displays.
module out_port_hex_display #(
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] out_port0,
  input  logic [4:0] out_port1,
  input  logic [4:0] out_port2,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [6:0] SEG_ZERO   = 7'b1000000;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] TENS_RESET = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  state_t          state_q, state_d;
  logic [2:0][4:0] ports;
  logic [2:0][4:0] snap_q, snap_d;
  logic [1:0]      idx_q, idx_d;
  logic [4:0]      w_q, w_d;
  logic [1:0]      tens_q, tens_d;
  logic [2:0][6:0] ones_seg_q, ones_seg_d;
  logic [2:0][6:0] tens_seg_q, tens_seg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [6:0]      ones_enc, tens_enc;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  assign ports    = {out_port2, out_port1, out_port0};
  assign ones_enc = enc(w_q[3:0]);
  assign tens_enc = (BLANK_LZ && tens_q == 2'd0) ? SEG_BLANK : enc({2'b00, tens_q});

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    w_d        = w_q;
    tens_d     = tens_q;
    ones_seg_d = ones_seg_q;
    tens_seg_d = tens_seg_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ports != snap_q) begin
          snap_d  = ports;
          w_d     = out_port0;
          tens_d  = 2'd0;
          idx_d   = 2'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (w_q >= 5'd10) begin
          w_d    = w_q - 5'd10;
          tens_d = tens_q + 2'd1;
        end else begin
          // w < 10 here, so ones_enc/tens_enc form the finished pair for port idx
          case (idx_q)
            2'd0: begin
              ones_seg_d[0] = ones_enc;
              tens_seg_d[0] = tens_enc;
              idx_d         = 2'd1;
              w_d           = snap_q[1];
              tens_d        = 2'd0;
            end
            2'd1: begin
              ones_seg_d[1] = ones_enc;
              tens_seg_d[1] = tens_enc;
              idx_d         = 2'd2;
              w_d           = snap_q[2];
              tens_d        = 2'd0;
            end
            default: begin
              ones_seg_d[2] = ones_enc;
              tens_seg_d[2] = tens_enc;
              state_d       = IDLE;
              done_d        = 1'b1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CONV);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= 2'd0;
      w_q        <= 5'd0;
      tens_q     <= 2'd0;
      ones_seg_q <= {3{SEG_ZERO}};
      tens_seg_q <= {3{TENS_RESET}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      w_q        <= w_d;
      tens_q     <= tens_d;
      ones_seg_q <= ones_seg_d;
      tens_seg_q <= tens_seg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign hex0 = ones_seg_q[0];
  assign hex1 = tens_seg_q[0];
  assign hex2 = ones_seg_q[1];
  assign hex3 = tens_seg_q[1];
  assign hex4 = ones_seg_q[2];
  assign hex5 = tens_seg_q[2];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_out_port_hex_display.sv
// Bench for out_port_hex_display: two instances (leading zero shown / blanked) share
// stimulus and are checked every cycle against a conversion-timeline model.
module tb_out_port_hex_display;

  logic            clock;
  logic            resetn;
  logic [4:0]      out_port0, out_port1, out_port2;
  logic [5:0][6:0] a_hex, b_hex;
  logic            a_busy, a_done, b_busy, b_done;

  out_port_hex_display #(.BLANK_LZ(1'b0)) dut_a (
    .clock(clock), .resetn(resetn),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .hex0(a_hex[0]), .hex1(a_hex[1]), .hex2(a_hex[2]),
    .hex3(a_hex[3]), .hex4(a_hex[4]), .hex5(a_hex[5]),
    .busy(a_busy), .done(a_done)
  );

  out_port_hex_display #(.BLANK_LZ(1'b1)) dut_b (
    .clock(clock), .resetn(resetn),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .hex0(b_hex[0]), .hex1(b_hex[1]), .hex2(b_hex[2]),
    .hex3(b_hex[3]), .hex4(b_hex[4]), .hex5(b_hex[5]),
    .busy(b_busy), .done(b_done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          chk_en   = 1'b0;
  logic [41:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;  1: seg = 7'b1111001;  2: seg = 7'b0100100;
      3: seg = 7'b0110000;  4: seg = 7'b0011001;  5: seg = 7'b0010010;
      6: seg = 7'b0000010;  7: seg = 7'b1111000;  8: seg = 7'b0000000;
      9: seg = 7'b0010000;  default: seg = 7'b1111111;
    endcase
  endfunction

  // Display of one value as {tens, ones}, optional blank for a zero tens digit.
  function automatic logic [13:0] pair(input int v, input bit blank);
    logic [6:0] t;
    t = (blank && v / 10 == 0) ? 7'b1111111 : seg(v / 10);
    pair = {t, seg(v % 10)};
  endfunction

  function automatic logic [41:0] pattern(input int v0, input int v1, input int v2, input bit blank);
    pattern = {pair(v2, blank), pair(v1, blank), pair(v0, blank)};
  endfunction

  // ---------------- reference model ----------------
  // A conversion is a timeline: port k finishes after sum_{j<=k}(v_j/10 + 1) cycles.
  int m_snap[3];
  int m_disp[3];
  int m_c, m_total;
  bit m_busy, m_done;

  always @(posedge clock) begin
    int acc;
    int nc;
    if (!resetn) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_c     <= 0;
      m_total <= 0;
      for (int k = 0; k < 3; k++) begin
        m_snap[k] <= 0;
        m_disp[k] <= 0;
      end
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        nc  = m_c + 1;
        acc = 0;
        for (int k = 0; k < 3; k++) begin
          acc += m_snap[k] / 10 + 1;
          if (nc == acc) m_disp[k] <= m_snap[k];
        end
        m_c <= nc;
        if (nc == m_total) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          exp_q.push_back(pattern(m_snap[0], m_snap[1], m_snap[2], 1'b0));
        end
      end else if (int'(out_port0) != m_snap[0] || int'(out_port1) != m_snap[1] ||
                   int'(out_port2) != m_snap[2]) begin
        m_snap[0] <= int'(out_port0);
        m_snap[1] <= int'(out_port1);
        m_snap[2] <= int'(out_port2);
        m_busy    <= 1'b1;
        m_c       <= 0;
        m_total   <= int'(out_port0) / 10 + int'(out_port1) / 10 + int'(out_port2) / 10 + 3;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cycle_a", {a_busy, a_done, a_hex},
          {m_busy, m_done, pattern(m_disp[0], m_disp[1], m_disp[2], 1'b0)});
      chk("cycle_b", {b_busy, b_done, b_hex},
          {m_busy, m_done, pattern(m_disp[0], m_disp[1], m_disp[2], 1'b1)});
      if (a_done) begin
        chk("done_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("done_value", a_hex, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ports(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
    @(negedge clock);
    out_port0 = p0;
    out_port1 = p1;
    out_port2 = p2;
  endtask

  task automatic wait_conv(output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (a_busy) nb++;
      if (a_done) begin
        nd++;
        break;
      end
    end
    chk("conv_done_seen", nd, 1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int nb, nd, cnt;
    resetn = 1'b0;
    out_port0 = 5'd0; out_port1 = 5'd0; out_port2 = 5'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    chk_en = 1'b1;

    // reset state, all ports zero
    chk("reset_a_hex", a_hex, {6{7'b1000000}});
    chk("reset_b_hex", b_hex, {3{7'b1111111, 7'b1000000}});
    chk("reset_busy", a_busy, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (a_done) cnt++;
    end
    chk("idle_no_done", cnt, 0);

    // 23 on port0
    set_ports(5'd23, 5'd0, 5'd0);
    wait_conv(nb, nd);
    chk("busy_23", nb, 5);
    chk("hex1_23", a_hex[1], 7'b0100100);
    chk("hex0_23", a_hex[0], 7'b0110000);
    chk("hex5_2_23", a_hex[5:2], {4{7'b1000000}});

    // all ports at maximum
    set_ports(5'd31, 5'd31, 5'd31);
    wait_conv(nb, nd);
    chk("busy_31", nb, 12);
    chk("hex_31", a_hex, {3{7'b0110000, 7'b1111001}});

    // change during conversion is deferred to a second pass
    set_ports(5'd15, 5'd5, 5'd9);
    @(negedge clock);
    @(negedge clock);
    out_port1 = 5'd17;
    wait_conv(nb, nd);
    chk("hex3_first", a_hex[3], 7'b1000000);
    chk("hex2_first", a_hex[2], 7'b0010010);
    @(negedge clock);
    chk("restart_busy", a_busy, 1);
    wait_conv(nb, nd);
    chk("busy_second", nb, 4);
    chk("hex3_second", a_hex[3], 7'b1111001);
    chk("hex2_second", a_hex[2], 7'b1111000);

    // blanked leading zero
    set_ports(5'd15, 5'd17, 5'd7);
    wait_conv(nb, nd);
    chk("b_hex5_blank", b_hex[5], 7'b1111111);
    chk("b_hex4_7", b_hex[4], 7'b1111000);
    chk("a_hex5_zero", a_hex[5], 7'b1000000);

    // reset mid-conversion aborts, then conversion restarts
    set_ports(5'd31, 5'd31, 5'd31);
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("midreset_a", {a_busy, a_done, a_hex}, {2'b00, {6{7'b1000000}}});
    chk("midreset_b", {b_busy, b_done, b_hex}, {2'b00, {3{7'b1111111, 7'b1000000}}});
    resetn = 1'b1;
    wait_conv(nb, nd);
    chk("busy_after_reset", nb, 12);
    chk("hex_after_reset", a_hex, {3{7'b0110000, 7'b1111001}});

    // random traffic, including changes mid-conversion and occasional resets
    for (int it = 0; it < 60; it++) begin
      @(negedge clock);
      case ($urandom_range(0, 9))
        0: out_port0 = 5'($urandom_range(0, 31));
        1: out_port1 = 5'($urandom_range(0, 31));
        2: out_port2 = 5'($urandom_range(0, 31));
        3: resetn = 1'b0;
        default: begin
          out_port0 = 5'($urandom_range(0, 31));
          out_port1 = 5'($urandom_range(0, 31));
          out_port2 = 5'($urandom_range(0, 31));
        end
      endcase
      @(negedge clock);
      resetn = 1'b1;
      repeat ($urandom_range(0, 14)) @(negedge clock);
    end

    repeat (40) @(negedge clock);
    chk("final_idle", a_busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/out_port_hex_display.md
# out_port_hex_display

Display stage directly downstream of the single-cycle computer's output ports. It watches `out_port0`, `out_port1` and `out_port2` (5-bit each, range 0..31) and converts each value to two decimal digits with a sequential subtract-by-ten FSM. It drives six active-low seven-segment outputs, `hex0`..`hex5`, as on the board. Outputs are fully registered and update only when an input value changes.

## Interface
- `BLANK_LZ`, default 0: when 1, a tens digit of 0 is shown blank (7'b1111111) instead of "0".
- `clock` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `out_port0` in 5: CPU output port 0; shown on `hex1` (tens) and `hex0` (ones).
- `out_port1` in 5: CPU output port 1; shown on `hex3` (tens) and `hex2` (ones).
- `out_port2` in 5: CPU output port 2; shown on `hex5` (tens) and `hex4` (ones).
- `hex0`..`hex5` out 7 each: segment drive, active-low, bit order [6:0] = g,f,e,d,c,b,a.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse on the cycle after the last digit pair is written.

## Operation
- Internal registers:
  - `state` ∈ {IDLE, CONV}
  - `snap0..2` (5b): values being or last displayed
  - `idx` (2b): port under conversion
  - `w` (5b): working remainder
  - `tens` (2b): tens count
- IDLE:
  - Each edge, compare {`out_port2`,`out_port1`,`out_port0`} with {`snap2`,`snap1`,`snap0`}.
  - If any differ: `snap*` <= inputs, `w` <= `out_port0`, `tens` <= 0, `idx` <= 0, `state` <= CONV.
  - Otherwise hold.
- CONV:
  - If `w` >= 10: `w` <= `w` - 10, `tens` <= `tens` + 1.
  - Else write the digit pair for port `idx`: ones segment <= enc(`w`), tens segment <= enc(`tens`), or blank if `BLANK_LZ` and `tens` == 0.
  - After the write, if `idx` == 2: `state` <= IDLE and `done` <= 1 for one cycle.
  - Otherwise: `idx` <= `idx` + 1, `w` <= `snap[idx+1]`, `tens` <= 0.
- Encoding (active-low), 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Arithmetic: unsigned 5-bit. The maximum input of 31 gives `tens` ≤ 3, so no overflow; `w` < 10 at every write.
- Input changes during CONV are ignored; the conversion uses `snap*`. On return to IDLE the next compare catches any pending change. No value is lost, but intermediate values may be skipped.
- `busy` = (`state` == CONV), registered.

## Timing
- Reset (`resetn`=0 at an edge) forces:
  - `state`=IDLE, `snap*`=0, `idx`=0, `w`=0, `tens`=0
  - `busy`=0, `done`=0
  - `hex0`, `hex2`, `hex4` = 1000000
  - `hex1`, `hex3`, `hex5` = 1000000 if `BLANK_LZ`=0, else 1111111
- Reset in the middle of CONV aborts immediately: partially written pairs revert to reset values.
- Change detected at edge E0 → CONV runs from E1.
- Port k with value v takes floor(v/10)+1 CONV cycles; its pair updates on the last of those cycles.
- Total CONV cycles = Σ(floor(vk/10)+1): minimum 3 (all <10), maximum 12 (all 31).
- `busy` is high from after E0 through the final CONV edge.
- `done` is high for the one cycle after the final CONV edge; `busy` falls at the same edge `done` rises.
- A new conversion can start on the IDLE edge following `done`, at the earliest 1 cycle after `done` rises.
- Unchanged inputs: no activity, outputs static indefinitely.

## Test plan
- Reset with all ports 0 → all hex = 1000000 (`BLANK_LZ`=0), `busy`=0; no `done` over 20 cycles.
- After reset, set `out_port0`=23, others 0 → `busy` high 5 cycles; `hex1`=0100100 and `hex0`=0110000 on the 3rd CONV edge; single `done` pulse; `hex2`..`hex5` = 1000000.
- Set all ports to 31 → `busy` high exactly 12 cycles; `hex1`/`hex3`/`hex5`=0110000 and `hex0`/`hex2`/`hex4`=1111001; `done` once.
- Change `out_port1` 5→17 on the 2nd CONV cycle of an active conversion → the first pass finishes showing 05 for port1; a second conversion starts right after `done` and ends with `hex3`=1111001, `hex2`=1111000.
- `BLANK_LZ`=1, `out_port2`=7 → `hex5`=1111111, `hex4`=1111000.
- Assert `resetn`=0 for one edge during CONV with ports 31 → all outputs return to reset values at that edge, then the conversion restarts and completes in 12 cycles.
